// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with bounded retries,
// then releases the downstream resets one by one and supervises lock while running.
module pll_reset_sequencer #(
    parameter int NUM_RST        = 4,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 1024,
    parameter int STAGGER_CYCLES = 8,
    parameter int MAX_RETRIES    = 3
) (
    input  logic               clk_in1,
    input  logic               reset,
    input  logic               pll_locked,
    output logic               pll_reset,
    output logic [NUM_RST-1:0] rst_out,
    output logic               ready,
    output logic               fault,
    output logic [7:0]         lock_loss_count
);

    localparam int REL_CYCLES = STAGGER_CYCLES * NUM_RST;
    localparam int CNT_MAX_A  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX    = (CNT_MAX_A > REL_CYCLES) ? CNT_MAX_A : REL_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int RTY_W      = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(REL_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX   = RTY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RTY_W-1:0]   retry_q;
    logic [RTY_W-1:0]   retry_d;
    logic [7:0]         llc_q;
    logic [7:0]         llc_d;
    logic               sync1_q;
    logic               lock_s_q;
    logic               pll_reset_q;
    logic [NUM_RST-1:0] rst_out_q;
    logic               ready_q;
    logic               fault_q;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            sync1_q  <= pll_locked;
            lock_s_q <= sync1_q;
        end
    end

    // Next values for the saturating lock-loss counter and the retry counter.
    always_comb begin
        llc_d   = llc_q;
        retry_d = retry_q + RTY_W'(1);
        if (llc_q != 8'hFF) begin
            llc_d = llc_q + 8'd1;
        end else begin
            llc_d = llc_q;
        end
    end

    // Sequencer FSM; outputs are registered and updated together with the state.
    always_ff @(posedge clk_in1 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= {CNT_W{1'b0}};
            retry_q     <= {RTY_W{1'b0}};
            llc_q       <= 8'd0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= {NUM_RST{1'b1}};
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_PLL_RST: begin
                    if (cnt_q == PLL_LAST) begin
                        cnt_q       <= {CNT_W{1'b0}};
                        state_q     <= ST_WAIT_LOCK;
                        pll_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        cnt_q   <= {CNT_W{1'b0}};
                        state_q <= ST_RELEASE;
                    end else if (cnt_q == LOCK_LAST) begin
                        cnt_q       <= {CNT_W{1'b0}};
                        retry_q     <= retry_d;
                        pll_reset_q <= 1'b1;
                        if (retry_d == RTY_MAX) begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= ST_PLL_RST;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE, ST_RUN: begin
                    // Lock loss wins over any stagger release due on this edge.
                    if (!lock_s_q) begin
                        state_q     <= ST_PLL_RST;
                        cnt_q       <= {CNT_W{1'b0}};
                        pll_reset_q <= 1'b1;
                        rst_out_q   <= {NUM_RST{1'b1}};
                        ready_q     <= 1'b0;
                        llc_q       <= llc_d;
                    end else if (state_q == ST_RELEASE) begin
                        for (int i = 0; i < NUM_RST; i++) begin
                            if (cnt_q == CNT_W'(STAGGER_CYCLES * (i + 1) - 1)) begin
                                rst_out_q[i] <= 1'b0;
                            end
                        end
                        if (cnt_q == REL_LAST) begin
                            cnt_q   <= {CNT_W{1'b0}};
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                            retry_q <= {RTY_W{1'b0}};
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_q <= {CNT_W{1'b0}};
                    end
                end
                ST_FAULT: begin
                    pll_reset_q <= 1'b1;
                    rst_out_q   <= {NUM_RST{1'b1}};
                    ready_q     <= 1'b0;
                    fault_q     <= 1'b1;
                end
                default: begin
                    state_q     <= ST_PLL_RST;
                    cnt_q       <= {CNT_W{1'b0}};
                    pll_reset_q <= 1'b1;
                    rst_out_q   <= {NUM_RST{1'b1}};
                    ready_q     <= 1'b0;
                    fault_q     <= 1'b0;
                end
            endcase
        end
    end

    assign pll_reset       = pll_reset_q;
    assign rst_out         = rst_out_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign lock_loss_count = llc_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer at default parameters; expected cycle
// positions are hand-derived from the release/timeout arithmetic.
module tb_pll_reset_sequencer;

    logic       clk_in1;
    logic       reset;
    logic       pll_locked;
    logic       pll_reset;
    logic [3:0] rst_out;
    logic       ready;
    logic       fault;
    logic [7:0] lock_loss_count;

    int checks;
    int errors;

    pll_reset_sequencer dut (
        .clk_in1         (clk_in1),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .pll_reset       (pll_reset),
        .rst_out         (rst_out),
        .ready           (ready),
        .fault           (fault),
        .lock_loss_count (lock_loss_count)
    );

    initial clk_in1 = 1'b0;
    always #5 clk_in1 = ~clk_in1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_in1);
        #1;
    endtask

    // Hold reset for a few edges, check reset values, release just after an edge.
    // The next rising edge is then edge 1 of the sequence.
    task automatic do_reset(input logic lk);
        reset      = 1'b1;
        pll_locked = lk;
        step(3);
        check_eq("rst_pll_reset", 32'(pll_reset), 32'd1);
        check_eq("rst_rst_out", 32'(rst_out), 32'hF);
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        check_eq("rst_llc", 32'(lock_loss_count), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        pll_locked = 1'b0;

        // Lock always high: RELEASE entered at edge 17, releases at 25/33/41/49.
        do_reset(1'b1);
        step(15);
        check_eq("t1_pll_reset_e15", 32'(pll_reset), 32'd1);
        check_eq("t1_rst_out_e15", 32'(rst_out), 32'hF);
        step(1);
        check_eq("t1_pll_reset_e16", 32'(pll_reset), 32'd0);
        step(8);
        check_eq("t1_rst_out_e24", 32'(rst_out), 32'hF);
        step(1);
        check_eq("t1_rst_out_e25", 32'(rst_out), 32'hE);
        step(8);
        check_eq("t1_rst_out_e33", 32'(rst_out), 32'hC);
        step(8);
        check_eq("t1_rst_out_e41", 32'(rst_out), 32'h8);
        step(7);
        check_eq("t1_ready_e48", 32'(ready), 32'd0);
        check_eq("t1_rst_out_e48", 32'(rst_out), 32'h8);
        step(1);
        check_eq("t1_ready_e49", 32'(ready), 32'd1);
        check_eq("t1_rst_out_e49", 32'(rst_out), 32'h0);
        check_eq("t1_llc", 32'(lock_loss_count), 32'd0);
        check_eq("t1_fault", 32'(fault), 32'd0);

        // One-cycle lock glitch in RUN (E = edge 49): drop seen at E+3, resequence.
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(1);
        check_eq("t3_ready_e2", 32'(ready), 32'd1);
        step(1);
        check_eq("t3_rst_out_e3", 32'(rst_out), 32'hF);
        check_eq("t3_ready_e3", 32'(ready), 32'd0);
        check_eq("t3_pll_reset_e3", 32'(pll_reset), 32'd1);
        check_eq("t3_llc", 32'(lock_loss_count), 32'd1);
        step(15);
        check_eq("t3_pll_reset_e18", 32'(pll_reset), 32'd1);
        step(1);
        check_eq("t3_pll_reset_e19", 32'(pll_reset), 32'd0);
        step(32);
        check_eq("t3_ready_e51", 32'(ready), 32'd0);
        check_eq("t3_rst_out_e51", 32'(rst_out), 32'h8);
        step(1);
        check_eq("t3_ready_e52", 32'(ready), 32'd1);
        check_eq("t3_rst_out_e52", 32'(rst_out), 32'h0);

        // Lock drop while rst_out=1100 (lock_s low in T+20): back to PLL_RST at edge 38.
        do_reset(1'b1);
        step(35);
        pll_locked = 1'b0;
        step(2);
        check_eq("t4_rst_out_e37", 32'(rst_out), 32'hC);
        step(1);
        check_eq("t4_rst_out_e38", 32'(rst_out), 32'hF);
        check_eq("t4_pll_reset_e38", 32'(pll_reset), 32'd1);
        check_eq("t4_llc", 32'(lock_loss_count), 32'd1);
        check_eq("t4_ready", 32'(ready), 32'd0);
        step(10);
        check_eq("t4_rst_out_e48", 32'(rst_out), 32'hF);
        pll_locked = 1'b1;
        step(17);
        check_eq("t4_rst_out_e65", 32'(rst_out), 32'hE);
        check_eq("t4_llc_e65", 32'(lock_loss_count), 32'd1);

        // Asynchronous reset between edges during RELEASE.
        #3;
        reset = 1'b1;
        #1;
        check_eq("t5_rst_out", 32'(rst_out), 32'hF);
        check_eq("t5_pll_reset", 32'(pll_reset), 32'd1);
        check_eq("t5_ready", 32'(ready), 32'd0);
        check_eq("t5_llc", 32'(lock_loss_count), 32'd0);
        step(1);
        reset = 1'b0;

        // Lock never arrives: timeouts at 1040 and 2080, FAULT at 3120.
        do_reset(1'b0);
        step(1039);
        check_eq("t2_pll_reset_e1039", 32'(pll_reset), 32'd0);
        step(1);
        check_eq("t2_pll_reset_e1040", 32'(pll_reset), 32'd1);
        check_eq("t2_fault_e1040", 32'(fault), 32'd0);
        step(16);
        check_eq("t2_pll_reset_e1056", 32'(pll_reset), 32'd0);
        step(1024);
        check_eq("t2_pll_reset_e2080", 32'(pll_reset), 32'd1);
        step(16);
        check_eq("t2_pll_reset_e2096", 32'(pll_reset), 32'd0);
        step(1023);
        check_eq("t2_pll_reset_e3119", 32'(pll_reset), 32'd0);
        check_eq("t2_fault_e3119", 32'(fault), 32'd0);
        step(1);
        check_eq("t2_fault_e3120", 32'(fault), 32'd1);
        check_eq("t2_pll_reset_e3120", 32'(pll_reset), 32'd1);
        check_eq("t2_rst_out_e3120", 32'(rst_out), 32'hF);
        check_eq("t2_ready_e3120", 32'(ready), 32'd0);
        pll_locked = 1'b1;
        step(2000);
        check_eq("t2_fault_hold", 32'(fault), 32'd1);
        check_eq("t2_pll_reset_hold", 32'(pll_reset), 32'd1);
        check_eq("t2_rst_out_hold", 32'(rst_out), 32'hF);
        check_eq("t2_ready_hold", 32'(ready), 32'd0);

        // 300 lock losses from RUN: counter saturates at 255.
        do_reset(1'b1);
        for (int i = 1; i <= 300; i++) begin
            int n;
            n = 0;
            while (ready !== 1'b1 && n < 200) begin
                step(1);
                n++;
            end
            if (ready !== 1'b1) begin
                check_eq("t6_ready_wait", 32'(ready), 32'd1);
                break;
            end
            pll_locked = 1'b0;
            step(4);
            pll_locked = 1'b1;
            if (i == 254) check_eq("t6_llc_254", 32'(lock_loss_count), 32'd254);
            if (i == 255) check_eq("t6_llc_255", 32'(lock_loss_count), 32'd255);
        end
        check_eq("t6_llc_sat", 32'(lock_loss_count), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter NUM_RST, default 4, SHALL set the number of sequenced reset outputs (range 1..16).
REQ-002 Parameter PLL_RST_CYCLES, default 16, SHALL set the pll_reset pulse width in clk_in1 cycles (at least 1).
REQ-003 Parameter LOCK_TIMEOUT, default 1024, SHALL set the WAIT_LOCK cycle limit before a retry (at least 2).
REQ-004 Parameter STAGGER_CYCLES, default 8, SHALL set the spacing between successive rst_out releases (at least 1).
REQ-005 Parameter MAX_RETRIES, default 3, SHALL set the number of consecutive lock timeouts that cause FAULT (at least 1).
REQ-006 clk_in1  input  1  SHALL be the single clock; all state SHALL be on its rising edge.
REQ-007 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-008 pll_locked  input  1  SHALL be the PLL lock indication, asynchronous to clk_in1.
REQ-009 pll_reset  output  1  SHALL be the active-high reset driven to the PLL.
REQ-010 rst_out  output  NUM_RST  SHALL be the active-high downstream domain resets; bit 0 releases first.
REQ-011 ready  output  1  SHALL be high only while the block is in RUN.
REQ-012 fault  output  1  SHALL be high only while the block is in FAULT.
REQ-013 lock_loss_count  output  8  SHALL be a saturating count of lock losses seen in RELEASE or RUN.

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchronizer (lock_s, reset value 0); all decisions SHALL use lock_s only.
REQ-015 The FSM SHALL have exactly five states: PLL_RST, WAIT_LOCK, RELEASE, RUN, FAULT.
REQ-016 All outputs SHALL be registered.
REQ-017 PLL_RST state:
  - pll_reset=1 and rst_out all ones;
  - after exactly PLL_RST_CYCLES cycles in this state, the FSM SHALL move to WAIT_LOCK;
  - the cycle counter SHALL clear on every state change.
REQ-018 WAIT_LOCK state:
  - pll_reset=0;
  - if lock_s=1, the FSM SHALL move to RELEASE on the next edge;
  - otherwise, after LOCK_TIMEOUT cycles it SHALL increment retry_cnt;
  - it SHALL then go to FAULT if retry_cnt reaches MAX_RETRIES, else to PLL_RST.
REQ-019 RELEASE state:
  - let T be the first cycle in RELEASE;
  - rst_out[i] SHALL deassert at T+STAGGER_CYCLES*(i+1) and stay low;
  - the FSM SHALL enter RUN, with ready=1, in the same cycle that rst_out[NUM_RST-1] deasserts.
REQ-020 On entering RUN, retry_cnt SHALL clear to 0.
REQ-021 If lock_s=0 in RELEASE or RUN:
  - on the next edge, rst_out SHALL return to all ones, ready SHALL go to 0, and the FSM SHALL go to PLL_RST;
  - lock_loss_count SHALL increment, saturating at 255 with no wrap.
REQ-022 Lock loss SHALL take priority over a stagger release scheduled for the same cycle.
REQ-023 FAULT state:
  - pll_reset=1, rst_out all ones, fault=1, ready=0;
  - FAULT is terminal until reset; pll_locked SHALL be ignored.
REQ-024 A lock_s glitch in WAIT_LOCK SHALL NOT be filtered: one high cycle is enough to enter RELEASE, and any later drop counts as a lock loss.

Reset
REQ-025 While reset=1, the block SHALL asynchronously hold these values:
  - state=PLL_RST, pll_reset=1, rst_out all ones, ready=0, fault=0;
  - lock_loss_count=0, retry_cnt=0, counter=0, synchronizer=0.
REQ-026 After reset deasserts, the PLL_RST_CYCLES count SHALL start on the first clk_in1 edge.
REQ-027 Reset asserted in any state, including mid-stagger or FAULT, SHALL restore the REQ-025 values immediately, without waiting for a clock.

Verification (defaults)
REQ-028 The bench SHALL cover: pll_locked constantly high from reset release ->
  - pll_reset high for 16 cycles;
  - rst_out[0..3] fall at T+8, T+16, T+24, T+32;
  - ready rises with rst_out[3]; lock_loss_count=0.
REQ-029 The bench SHALL cover: pll_locked constantly low ->
  - 3 pll_reset pulses of 16 cycles each, separated by 1024-cycle waits;
  - then fault=1, pll_reset=1, rst_out=4'b1111, held for at least 2000 further cycles.
REQ-030 The bench SHALL cover: in RUN, pll_locked low for 1 cycle ->
  - rst_out=4'b1111 and ready=0 within 3 cycles; lock_loss_count=1;
  - full resequence once lock returns.
REQ-031 The bench SHALL cover: lock drop at T+20 in RELEASE, when rst_out=4'b1100 ->
  - rst_out returns to 4'b1111; rst_out[2] never releases; FSM re-enters PLL_RST; lock_loss_count=1.
REQ-032 The bench SHALL cover: 300 lock-loss events -> lock_loss_count saturates at 255.
REQ-033 The bench SHALL cover: reset asserted between clock edges during RELEASE ->
  - rst_out=4'b1111 and pll_reset=1 before the next clk_in1 edge;
  - lock_loss_count=0 afterwards.
